logic_lamp_bank: RTL and testbench

- Input side of a multi-input logic gate: a bank of logic lamps that wire pulses toggle, presented as the gate's `in` vector.
- Wire pulses are collected into a shadow state over a fixed evaluation frame.
- At frame end the shadow state is committed to `lamp_state`, and `eval` pulses if the committed state changed.
- Excessive toggling within one frame latches a sticky overload that freezes the bank until reset.

---
 rtl/logic_lamp_bank.sv | 111 +++++++++++
 tb/tb_logic_lamp_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_lamp_bank.sv
// logic_lamp_bank: input side of a multi-input logic gate.
// Wire pulses toggle a shadow copy of the lamps every cycle. At the end of each
// fixed-length evaluation frame the shadow is committed to lamp_state, and eval
// flags a change. Too many toggle events in one frame latch a sticky overload
// that freezes lamp_state until logic_reset.
module logic_lamp_bank #(
    parameter int                    LAMP_COUNT   = 2,
    parameter int                    FRAME_CYCLES = 4,
    parameter int                    MAX_TOGGLES  = 8,
    parameter logic [LAMP_COUNT-1:0] INIT_STATE   = '0
) (
    input  logic                  clk,
    input  logic                  logic_reset,
    input  logic [LAMP_COUNT-1:0] toggle,
    output logic [LAMP_COUNT-1:0] lamp_state,
    output logic                  eval,
    output logic                  frame_end,
    output logic                  overload
);

    // A one-cycle frame still needs a 1-bit counter that simply stays at zero.
    localparam int FC_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int TC_W  = $clog2(MAX_TOGGLES + 2);
    localparam int PC_W  = $clog2(LAMP_COUNT + 1);
    // One spare bit so that tc + pc can never wrap before it is compared.
    localparam int SUM_W = ((TC_W > PC_W) ? TC_W : PC_W) + 1;

    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FRAME_CYCLES - 1);
    localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'(MAX_TOGGLES);
    localparam logic [SUM_W-1:0] SUM_SAT = SUM_W'(MAX_TOGGLES + 1);
    localparam logic [TC_W-1:0]  TC_SAT  = TC_W'(MAX_TOGGLES + 1);

    logic [LAMP_COUNT-1:0] shadow_q, shadow_d;
    logic [LAMP_COUNT-1:0] lamp_q, lamp_d;
    logic [FC_W-1:0]       fc_q, fc_d;
    logic [TC_W-1:0]       tc_q, tc_d;
    logic                  eval_q, eval_d;
    logic                  frame_end_q, frame_end_d;
    logic                  overload_q, overload_d;

    logic [PC_W-1:0]       pc;
    logic [SUM_W-1:0]      tc_sum;
    logic                  commit;
    logic                  over_now;

    // Count how many lamps are pulsed this cycle; each pulsed lamp is one event.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pc = '0;
        for (int i = 0; i < LAMP_COUNT; i++) begin
            pc = pc + PC_W'(toggle[i]);
        end
    end

    assign tc_sum   = SUM_W'(tc_q) + SUM_W'(pc);
    assign commit   = (fc_q == FC_LAST);
    assign over_now = (tc_sum > SUM_MAX);

    // Next-state logic: shadow, frame/toggle counters, overload and commit outputs.
    always_comb begin
        shadow_d    = shadow_q ^ toggle;
        fc_d        = commit ? '0 : fc_q + FC_W'(1);
        overload_d  = overload_q | over_now;
        lamp_d      = lamp_q;
        eval_d      = 1'b0;
        frame_end_d = commit;

        if (commit) begin
            tc_d = '0;
        end else if (tc_sum >= SUM_SAT) begin
            tc_d = TC_SAT;
        end else begin
            tc_d = tc_sum[TC_W-1:0];
        end

        // Include the commit cycle's own toggles; an overload landing on this
        // same edge already blocks the update.
        if (commit && !overload_d) begin
            lamp_d = shadow_d;
            eval_d = (shadow_d != lamp_q);
        end
    end

    // State registers with asynchronous clear; reset discards pending shadow changes.
    always_ff @(posedge clk or posedge logic_reset) begin
        if (logic_reset) begin
            shadow_q    <= INIT_STATE;
            lamp_q      <= INIT_STATE;
            fc_q        <= '0;
            tc_q        <= '0;
            eval_q      <= 1'b0;
            frame_end_q <= 1'b0;
            overload_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            shadow_q    <= shadow_d;
            lamp_q      <= lamp_d;
            fc_q        <= fc_d;
            tc_q        <= tc_d;
            eval_q      <= eval_d;
            frame_end_q <= frame_end_d;
            overload_q  <= overload_d;
        end
    end

    assign lamp_state = lamp_q;
    assign eval       = eval_q;
    assign frame_end  = frame_end_q;
    assign overload   = overload_q;

endmodule

// File: tb/tb_logic_lamp_bank.sv
// Testbench for logic_lamp_bank with LAMP_COUNT=2, FRAME_CYCLES=4, MAX_TOGGLES=3.
// A frame-level reference model (edge count modulo frame length, unbounded
// per-frame event tally) predicts the outputs after every rising edge.
module tb_logic_lamp_bank;

    localparam int FC   = 4;
    localparam int MAXT = 3;

    logic       clk = 1'b0;
    logic       logic_reset;
    logic [1:0] toggle;
    logic [1:0] lamp_state;
    logic       eval;
    logic       frame_end;
    logic       overload;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] m_shadow;
    int         m_cycle;
    int         m_events;
    logic       m_over;
    logic [1:0] exp_lamp;
    logic       exp_eval;
    logic       exp_fe;
    logic       exp_ov;

    logic_lamp_bank #(
        .LAMP_COUNT  (2),
        .FRAME_CYCLES(FC),
        .MAX_TOGGLES (MAXT),
        .INIT_STATE  (2'b00)
    ) dut (
        .clk        (clk),
        .logic_reset(logic_reset),
        .toggle     (toggle),
        .lamp_state (lamp_state),
        .eval       (eval),
        .frame_end  (frame_end),
        .overload   (overload)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input bit ok, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s", msg);
        end
    endtask

    task automatic reset_model();
        m_shadow = 2'b00;
        m_cycle  = 0;
        m_events = 0;
        m_over   = 1'b0;
        exp_lamp = 2'b00;
        exp_eval = 1'b0;
        exp_fe   = 1'b0;
        exp_ov   = 1'b0;
    endtask

    // Frame-level rules applied to one rising edge.
    task automatic model_edge(input logic [1:0] tog);
        int k;
        k = m_cycle % FC;
        m_events += $countones(tog);
        if (m_events > MAXT) m_over = 1'b1;
        m_shadow ^= tog;
        if (k == FC - 1) begin
            exp_fe = 1'b1;
            if (!m_over) begin
                exp_eval = (m_shadow != exp_lamp);
                exp_lamp = m_shadow;
            end else begin
                exp_eval = 1'b0;
            end
            m_events = 0;
        end else begin
            exp_fe   = 1'b0;
            exp_eval = 1'b0;
        end
        m_cycle++;
        exp_ov = m_over;
    endtask

    // Apply one cycle of toggles (called at posedge+1) and advance to posedge+1.
    task automatic drive_edge(input logic [1:0] tog);
        toggle = tog;
        @(posedge clk);
        #1;
        toggle = 2'b00;
        model_edge(tog);
    endtask

    task automatic align_frame();
        while (m_cycle % FC != 0) drive_edge(2'b00);
    endtask

    task automatic do_reset();
        logic_reset = 1'b1;
        @(posedge clk);
        #1;
        logic_reset = 1'b0;
        reset_model();
    endtask

    function automatic bit outputs_match();
        return {lamp_state, eval, frame_end, overload} === {exp_lamp, exp_eval, exp_fe, exp_ov};
    endfunction

    function automatic string outputs_msg(input string tag);
        return $sformatf("%s got lamp=%b eval=%b fe=%b ov=%b want lamp=%b eval=%b fe=%b ov=%b",
                         tag, lamp_state, eval, frame_end, overload,
                         exp_lamp, exp_eval, exp_fe, exp_ov);
    endfunction

    task automatic test_reset();
        logic_reset = 1'b1;
        toggle      = 2'b00;
        reset_model();
        #2;
        for (int i = 0; i < 3; i++) begin
            check({lamp_state, eval, frame_end, overload} === 5'b00000,
                  $sformatf("reset[%0d] got lamp=%b eval=%b fe=%b ov=%b want lamp=00 eval=0 fe=0 ov=0",
                            i, lamp_state, eval, frame_end, overload));
            toggle = 2'b11;
            @(posedge clk);
            #1;
            toggle = 2'b00;
        end
        logic_reset = 1'b0;
        reset_model();
    endtask

    task automatic test_idle();
        for (int i = 1; i <= 12; i++) begin
            drive_edge(2'b00);
            check(outputs_match(), outputs_msg($sformatf("idle edge%0d", i)));
        end
    endtask

    // Runs two frames with the given per-cycle toggles in the first frame.
    task automatic test_frame(input string name, input logic [1:0] t0, input logic [1:0] t1,
                              input logic [1:0] t2, input logic [1:0] t3);
        logic [1:0] pat [4];
        pat = '{t0, t1, t2, t3};
        align_frame();
        for (int i = 0; i < 2 * FC; i++) begin
            drive_edge(i < FC ? pat[i] : 2'b00);
            check(outputs_match(), outputs_msg($sformatf("%s cyc%0d", name, i)));
        end
    endtask

    task automatic test_random();
        logic [1:0] tog;
        for (int i = 0; i < 30 * FC; i++) begin
            tog = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            if (m_events + $countones(tog) > MAXT) tog = 2'b00;
            drive_edge(tog);
            check(outputs_match(), outputs_msg($sformatf("random cyc%0d", i)));
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        test_frame("pre_reset", 2'b00, 2'b01, 2'b00, 2'b00);
        align_frame();
        drive_edge(2'b00);
        drive_edge(2'b10);
        // Asynchronous assertion between edges.
        logic_reset = 1'b1;
        #1;
        check({lamp_state, eval, frame_end, overload} === 5'b00000,
              $sformatf("async_reset got lamp=%b eval=%b fe=%b ov=%b want lamp=00 eval=0 fe=0 ov=0",
                        lamp_state, eval, frame_end, overload));
        @(posedge clk);
        #1;
        logic_reset = 1'b0;
        reset_model();
        for (int i = 1; i <= FC + 1; i++) begin
            drive_edge(2'b00);
            check({lamp_state, frame_end} === {2'b00, (i == FC)},
                  $sformatf("post_reset edge%0d got lamp=%b fe=%b want lamp=00 fe=%b",
                            i, lamp_state, frame_end, (i == FC)));
        end
    endtask

    task automatic test_overload();
        logic [1:0] tog;
        do_reset();
        drive_edge(2'b11);
        drive_edge(2'b11);
        check(overload === 1'b1, $sformatf("overload_set got ov=%b want ov=1", overload));
        for (int i = 0; i < 4 * FC; i++) begin
            tog = 2'($urandom);
            drive_edge(tog);
            check(outputs_match(), outputs_msg($sformatf("overload cyc%0d", i)));
        end
        check(lamp_state === 2'b00,
              $sformatf("overload_frozen got lamp=%b want lamp=00", lamp_state));
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame("single_toggle", 2'b00, 2'b01, 2'b00, 2'b00);
        test_frame("net_zero", 2'b01, 2'b00, 2'b01, 2'b00);
        test_frame("commit_cycle", 2'b00, 2'b00, 2'b00, 2'b11);
        test_frame("simultaneous", 2'b10, 2'b00, 2'b01, 2'b00);
        test_random();
        test_reset_mid_frame();
        test_overload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
